speed_selector: RTL and testbench

Converts two raw pushbuttons (up/down) into the 20-bit `speed` word, in Hz, that drives the clock divider's speed input. Each input is synchronized and debounced. Presses are turned into doubling/halving steps, which saturate at programmable limits. The block sits between the board buttons and the clock divider. Its output only changes on clean, debounced events, so the divider never sees a glitching ratio.

---
 rtl/speed_selector.sv | 203 ++++++++++++++++++++
 tb/tb_speed_selector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_selector.sv
// speed_selector: two raw pushbuttons (up/down) -> 20-bit speed word in Hz.
// Each button is synchronized (2 flops) and debounced. A debounced press
// doubles (up) or halves (down) the speed, saturating at SPEED_MIN/SPEED_MAX.
// Optional auto-repeat while a single button is held is compiled in when the
// macro SPEED_SELECTOR_AUTOREPEAT_EN is defined; otherwise a hold gives one step.
module speed_selector #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int SPEED_MIN       = 1,
    parameter int SPEED_MAX       = 1_000_000,
    parameter int SPEED_INIT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [19:0] speed,
    output logic        speed_changed,
    output logic        at_min,
    output logic        at_max
);

    // Elaboration-time guard against an illegal parameter set.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        SPEED_MIN < 1 || SPEED_MAX > 20'hFFFFF || SPEED_MAX < SPEED_MIN ||
        SPEED_INIT < SPEED_MIN || SPEED_INIT > SPEED_MAX) begin : g_param_check
        $error("speed_selector: illegal parameter set");
    end

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0]     MIN20   = 20'(SPEED_MIN);
    localparam logic [19:0]     MAX20   = 20'(SPEED_MAX);
    localparam logic [20:0]     MAX21   = 21'(SPEED_MAX);
    localparam logic [19:0]     INIT20  = 20'(SPEED_INIT);

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_stable;
    logic [1:0]      r_stable_d;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      r_evt;
    logic [1:0]      w_press;
    logic [1:0]      w_rep_step;

    logic [19:0] r_speed;
    logic        r_changed;
    logic        r_at_min;
    logic        r_at_max;

    // Synchronize both raw buttons and debounce each into a stable level.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: the small per-button counter array is reset together with the
    // rest of the state so an interrupted debounce never carries over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_stable <= 2'b00;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= {btn_down, btn_up};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a rising edge of the debounced level; releases are ignored.
    assign w_press = r_stable & ~r_stable_d;

    // Delay the stable level for edge detection and register press events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_d <= 2'b00;
            r_evt      <= 2'b00;
        end else begin
            r_stable_d <= r_stable;
            r_evt      <= w_press;
        end
    end

`ifdef SPEED_SELECTOR_AUTOREPEAT_EN
    localparam int             REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             REP_W      = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t       r_rep_state;
    logic             r_rep_dir;   // 0 = up held, 1 = down held
    logic [REP_W-1:0] r_rep_cnt;
    logic [1:0]       r_rep_step;
    logic [1:0]       w_held_mask;

    assign w_held_mask = r_rep_dir ? 2'b10 : 2'b01;

    // Auto-repeat FSM: arm on a lone press, step while exactly that button is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_state <= IDLE;
            r_rep_dir   <= 1'b0;
            r_rep_cnt   <= '0;
            r_rep_step  <= 2'b00;
        end else begin
            r_rep_step <= 2'b00;
            if (w_press != 2'b00 && (r_stable == 2'b01 || r_stable == 2'b10)) begin
                r_rep_state <= DELAY;
                r_rep_dir   <= r_stable[1];
                r_rep_cnt   <= '0;
            end else if (r_rep_state != IDLE && r_stable != w_held_mask) begin
                // Release, or the other button joined: abandon without a step.
                r_rep_state <= IDLE;
                r_rep_cnt   <= '0;
            end else begin
                case (r_rep_state)
                    DELAY: begin
                        if (r_rep_cnt == DELAY_LAST) begin
                            r_rep_step[r_rep_dir] <= 1'b1;
                            r_rep_state           <= REPEAT;
                            r_rep_cnt             <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_rep_cnt == PERIOD_LAST) begin
                            r_rep_step[r_rep_dir] <= 1'b1;
                            r_rep_cnt             <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    default: r_rep_cnt <= '0;
                endcase
            end
        end
    end

    assign w_rep_step = r_rep_step;
`else
    assign w_rep_step = 2'b00;
`endif

    logic        w_up;
    logic        w_dn;
    logic [20:0] w_dbl;
    logic [19:0] w_half;
    logic [19:0] w_up_next;
    logic [19:0] w_dn_next;
    logic [19:0] w_next;

    assign w_up      = r_evt[0] | w_rep_step[0];
    assign w_dn      = r_evt[1] | w_rep_step[1];
    assign w_dbl     = {r_speed, 1'b0};
    assign w_half    = {1'b0, r_speed[19:1]};
    assign w_up_next = (w_dbl > MAX21) ? MAX20 : w_dbl[19:0];
    assign w_dn_next = (w_half < MIN20) ? MIN20 : w_half;

    // Select the next speed; simultaneous up and down steps cancel.
    // NOTE: w_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_speed;
        if (w_up && !w_dn) begin
            w_next = w_up_next;
        end else if (w_dn && !w_up) begin
            w_next = w_dn_next;
        end
    end

    // Output register: speed, change pulse and limit flags share one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_speed   <= INIT20;
            r_changed <= 1'b0;
            r_at_min  <= (INIT20 == MIN20);
            r_at_max  <= (INIT20 == MAX20);
        end else begin
            r_speed   <= w_next;
            r_changed <= (w_next != r_speed);
            r_at_min  <= (w_next == MIN20);
            r_at_max  <= (w_next == MAX20);
        end
    end

    assign speed         = r_speed;
    assign speed_changed = r_changed;
    assign at_min        = r_at_min;
    assign at_max        = r_at_max;

endmodule

// File: tb/tb_speed_selector.sv
// Self-checking bench for speed_selector. A window-based behavioural model
// predicts speed/flags/pulse every cycle; directed tests add literal checks.
// Define SPEED_SELECTOR_AUTOREPEAT_EN to build and check the auto-repeat variant.
module tb_speed_selector;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int SMIN = 1;
    localparam int SMAX = 1_000_000;
    localparam int SINI = 1;
    localparam int MAXC = 4096;

`ifdef SPEED_SELECTOR_AUTOREPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        btn_up;
    logic        btn_down;
    logic [19:0] speed;
    logic        speed_changed;
    logic        at_min;
    logic        at_max;

    speed_selector #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .SPEED_MIN      (SMIN),
        .SPEED_MAX      (SMAX),
        .SPEED_INIT     (SINI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .speed        (speed),
        .speed_changed(speed_changed),
        .at_min       (at_min),
        .at_max       (at_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per-edge history: sampled input (0 while in reset), debounced level,
    // press flag, repeat-armed flag and the edge where the repeat was armed.
    bit in_h [2][MAXC];
    bit st_h [2][MAXC];
    bit pr_h [2][MAXC];
    bit va_h [2][MAXC];
    int an_h [2][MAXC];
    bit r_h  [MAXC];

    int m_speed;
    bit m_chg;
    bit model_on = 1'b0;

    // The level flips when the D samples that reached the debouncer all
    // disagree with it and no reset touched that window.
    function automatic bit win_flip(int b, int n);
        if (n < D + 2) return 1'b0;
        for (int k = 1; k <= D + 1; k++) if (r_h[n-k]) return 1'b0;
        for (int k = 2; k <= D + 1; k++) if (in_h[b][n-k] == st_h[b][n-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit step_due(int b, int n);
        int d;
        if (n < 2 || r_h[n-1]) return 1'b0;
        if (pr_h[b][n-2]) return 1'b1;
        if (!AUTO_REP || !va_h[b][n-2]) return 1'b0;
        d = n - 2 - an_h[b][n-2];
        return (d >= RD) && (((d - RD) % RP) == 0);
    endfunction

    initial begin
        int  n;
        bit  up_s, dn_s;
        n = 0;
        forever begin
            @(posedge clk);
            if (n >= MAXC) begin
                $display("FAIL model_capacity: got %0d, expected below %0d", n, MAXC);
                $fatal(1);
            end
            r_h[n]     = rst;
            in_h[0][n] = rst ? 1'b0 : btn_up;
            in_h[1][n] = rst ? 1'b0 : btn_down;
            if (rst) begin
                for (int b = 0; b < 2; b++) begin
                    st_h[b][n] = 1'b0;
                    pr_h[b][n] = 1'b0;
                    va_h[b][n] = 1'b0;
                    an_h[b][n] = 0;
                end
                m_speed  = SINI;
                m_chg    = 1'b0;
                model_on = 1'b1;
            end else begin
                for (int b = 0; b < 2; b++)
                    st_h[b][n] = win_flip(b, n) ? ~st_h[b][n-1] : st_h[b][n-1];
                for (int b = 0; b < 2; b++) begin
                    pr_h[b][n] = st_h[b][n] && !st_h[b][n-1];
                    if (pr_h[b][n] && !st_h[1-b][n]) begin
                        va_h[b][n] = 1'b1;
                        an_h[b][n] = n;
                    end else if (va_h[b][n-1] && st_h[b][n] && !st_h[1-b][n]) begin
                        va_h[b][n] = 1'b1;
                        an_h[b][n] = an_h[b][n-1];
                    end else begin
                        va_h[b][n] = 1'b0;
                        an_h[b][n] = 0;
                    end
                end
                up_s = step_due(0, n);
                dn_s = step_due(1, n);
                begin
                    int nxt;
                    nxt = m_speed;
                    if (up_s && !dn_s)      nxt = (2 * m_speed > SMAX) ? SMAX : 2 * m_speed;
                    else if (dn_s && !up_s) nxt = (m_speed / 2 < SMIN) ? SMIN : m_speed / 2;
                    m_chg   = (nxt != m_speed);
                    m_speed = nxt;
                end
            end
            n++;
        end
    end

    // Compare DUT against the model mid-cycle, and count observed pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("cyc_speed", speed, m_speed);
                check("cyc_changed", speed_changed, m_chg);
                check("cyc_at_min", at_min, m_speed == SMIN);
                check("cyc_at_max", at_max, m_speed == SMAX);
                if (speed_changed === 1'b1) pulse_cnt++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic settle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        rst = 1'b1;
        repeat (k) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input logic u, input logic d);
        @(negedge clk);
        btn_up   = u;
        btn_down = d;
        repeat (8) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int p0;
        int exp_sp;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // Reset held for 3 edges.
        settle(3);
        check("reset_speed", speed, 1);
        check("reset_at_min", at_min, 1);
        check("reset_at_max", at_max, 0);
        check("reset_changed", speed_changed, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean 10-cycle press: new speed exactly 7 edges after first sample.
        @(negedge clk);
        btn_up = 1'b1;
        p0 = pulse_cnt;
        settle(1);            // edge E
        settle(6);            // edge E+6
        check("press_e6_speed", speed, 1);
        settle(1);            // edge E+7
        check("press_e7_speed", speed, 2);
        check("press_e7_pulse", speed_changed, 1);
        settle(1);
        check("press_e8_pulse", speed_changed, 0);
        settle(1);            // edge E+9: tenth sampled high
        @(negedge clk);
        btn_up = 1'b0;
        settle(15);
        check("press_pulses", pulse_cnt - p0, 1);
        check("release_speed", speed, 2);

        // Bouncing input never settles for D cycles.
        do_reset(2);
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_up = 1'b1;
            repeat (2) @(negedge clk);
            btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        settle(12);
        check("bounce_speed", speed, 1);
        check("bounce_pulses", pulse_cnt - p0, 0);

        // Down at the lower limit: no change, no pulse.
        press(1'b0, 1'b1);
        check("down_at_min_speed", speed, 1);
        check("down_at_min_pulses", pulse_cnt - p0, 0);

        // Climb to saturation, then simultaneous presses, then one down.
        for (int i = 0; i < 19; i++) press(1'b1, 1'b0);
        check("up19_speed", speed, 524_288);
        press(1'b1, 1'b0);
        check("up20_speed", speed, 1_000_000);
        check("up20_at_max", at_max, 1);
        p0 = pulse_cnt;
        press(1'b1, 1'b0);
        check("up21_speed", speed, 1_000_000);
        check("up21_pulses", pulse_cnt - p0, 0);
        press(1'b1, 1'b1);
        check("both_speed", speed, 1_000_000);
        check("both_pulses", pulse_cnt - p0, 0);
        press(1'b0, 1'b1);
        check("down_speed", speed, 500_000);
        check("down_at_max", at_max, 0);

        // Long hold from speed 1: auto-repeat steps at +0,+20,+25,+30,+35.
        do_reset(1);
        p0 = pulse_cnt;
        @(negedge clk);
        btn_up = 1'b1;
        settle(1);            // edge E
        settle(26);           // edge E+26
        check("hold_e26_speed", speed, 2);
        settle(1);            // edge E+27
        exp_sp = AUTO_REP ? 4 : 2;
        check("hold_e27_speed", speed, exp_sp);
        settle(8);            // edge E+35
        @(negedge clk);
        btn_up = 1'b0;        // debounced release lands before the +40 step
        settle(30);
        exp_sp = AUTO_REP ? 32 : 2;
        check("hold_final_speed", speed, exp_sp);
        exp_sp = AUTO_REP ? 5 : 1;
        check("hold_pulses", pulse_cnt - p0, exp_sp);

        // Reset in the middle of a down debounce, then release.
        do_reset(1);
        p0 = pulse_cnt;
        @(negedge clk);
        btn_down = 1'b1;
        settle(4);            // edges E..E+3: debounce count reaches 2
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        btn_down = 1'b0;
        settle(20);
        check("rst_mid_speed", speed, 1);
        check("rst_mid_pulses", pulse_cnt - p0, 0);
        check("rst_mid_at_min", at_min, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
